// File: rtl/ovc_credit_status_pkg.sv
// Constants shared by the router blocks: output-VC state encoding and
// the width helper used for the credit counters.
package ovc_credit_status_pkg;

    typedef enum logic {
        VC_IDLE = 1'b0,
        VC_BUSY = 1'b1
    } vc_state_e;

    // Smallest r with 2**r >= n; used to size a counter holding 0..B.
    function automatic int ovc_clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ovc_credit_counter.sv
// One downstream credit counter: starts full at B, decrements on a sent
// flit, increments on a returned credit, saturates at 0 and B and pulses
// err_o whenever a saturation would otherwise be crossed.
module ovc_credit_counter
    import ovc_credit_status_pkg::*;
#(
    parameter int B  = 4,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dec_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o,
    output logic          err_o
);

    localparam logic [CW-1:0] CNT_MAX = CW'(B);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          err;

    // Next count; simultaneous dec and inc cancel out.
    always_comb begin
        cnt_d = cnt_q;
        err   = 1'b0;
        if (dec_i && !inc_i) begin
            if (cnt_q == '0) begin
                err = 1'b1;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end else if (inc_i && !dec_i) begin
            if (cnt_q == CNT_MAX) begin
                err = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Counter register, reset to a full set of credits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= CNT_MAX;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = err;

endmodule

// File: rtl/ovc_credit_status.sv
// Per-output-port OVC ownership and credit tracker. All status outputs
// are decoded from registered state only, so every input event shows up
// one cycle later.
module ovc_credit_status
    import ovc_credit_status_pkg::*;
#(
    parameter int V = 4,
    parameter int B = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [V-1:0]                           ovc_allocated,
    input  logic [V-1:0]                           ovc_released,
    input  logic [V-1:0]                           flit_sent,
    input  logic [V-1:0]                           credit_in,
    output logic [V-1:0]                           ovc_avail,
    output logic [V-1:0]                           ovc_full,
    output logic [V-1:0]                           ovc_nearly_full,
    output logic [V-1:0]                           ovc_empty,
    output logic [V*ovc_clog2(B+1)-1:0]            credit_cnt_all,
    output logic                                   credit_err,
    output logic                                   alloc_err
);

    localparam int CW = ovc_clog2(B + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(B);

    vc_state_e     state_q [V];
    vc_state_e     state_d [V];
    logic [V-1:0]  vc_alloc_err;
    logic [V-1:0]  cnt_err;
    logic [CW-1:0] cnt [V];
    logic          alloc_multi;
    logic          release_multi;
    logic          credit_err_q, credit_err_d;
    logic          alloc_err_q, alloc_err_d;

    // More than one bit set in a grant vector is a protocol violation.
    assign alloc_multi   = |(ovc_allocated & (ovc_allocated - V'(1)));
    assign release_multi = |(ovc_released & (ovc_released - V'(1)));

    // Per-VC ownership next state plus protocol checks.
    always_comb begin
        vc_alloc_err = '0;
        for (int i = 0; i < V; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                VC_IDLE: begin
                    if (ovc_allocated[i] && !ovc_released[i]) begin
                        state_d[i] = VC_BUSY;
                    end
                    if (!ovc_allocated[i] && (ovc_released[i] || flit_sent[i])) begin
                        vc_alloc_err[i] = 1'b1;
                    end
                end
                VC_BUSY: begin
                    if (ovc_released[i] && !ovc_allocated[i]) begin
                        state_d[i] = VC_IDLE;
                    end
                    if (ovc_allocated[i] && !ovc_released[i]) begin
                        vc_alloc_err[i] = 1'b1;
                    end
                end
                default: state_d[i] = VC_IDLE;
            endcase
        end
    end

    // Sticky error flags accumulate until reset.
    always_comb begin
        credit_err_d = credit_err_q | (|cnt_err);
        alloc_err_d  = alloc_err_q | alloc_multi | release_multi | (|vc_alloc_err);
    end

    // State and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < V; i++) begin
                state_q[i] <= VC_IDLE;
            end
            credit_err_q <= 1'b0;
            alloc_err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < V; i++) begin
                state_q[i] <= state_d[i];
            end
            credit_err_q <= credit_err_d;
            alloc_err_q  <= alloc_err_d;
        end
    end

    for (genvar g = 0; g < V; g++) begin : g_vc
        ovc_credit_counter #(
            .B  (B),
            .CW (CW)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .dec_i (flit_sent[g]),
            .inc_i (credit_in[g]),
            .cnt_o (cnt[g]),
            .err_o (cnt_err[g])
        );

        assign ovc_avail[g]       = (state_q[g] == VC_IDLE);
        assign ovc_full[g]        = (cnt[g] == '0);
        assign ovc_nearly_full[g] = (cnt[g] <= CW'(1));
        assign ovc_empty[g]       = (state_q[g] == VC_IDLE) && (cnt[g] == CNT_MAX);
        assign credit_cnt_all[g*CW +: CW] = cnt[g];
    end

    assign credit_err = credit_err_q;
    assign alloc_err  = alloc_err_q;

endmodule

// File: tb/tb_ovc_credit_status.sv
// Directed bench for ovc_credit_status with V=4, B=4 (3-bit counters).
module tb_ovc_credit_status;

    localparam int V  = 4;
    localparam int B  = 4;
    localparam int CW = 3;

    logic            clk;
    logic            reset;
    logic [V-1:0]    ovc_allocated;
    logic [V-1:0]    ovc_released;
    logic [V-1:0]    flit_sent;
    logic [V-1:0]    credit_in;
    logic [V-1:0]    ovc_avail;
    logic [V-1:0]    ovc_full;
    logic [V-1:0]    ovc_nearly_full;
    logic [V-1:0]    ovc_empty;
    logic [V*CW-1:0] credit_cnt_all;
    logic            credit_err;
    logic            alloc_err;

    int n_checks;
    int n_errors;

    ovc_credit_status #(
        .V (V),
        .B (B)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ovc_allocated   (ovc_allocated),
        .ovc_released    (ovc_released),
        .flit_sent       (flit_sent),
        .credit_in       (credit_in),
        .ovc_avail       (ovc_avail),
        .ovc_full        (ovc_full),
        .ovc_nearly_full (ovc_nearly_full),
        .ovc_empty       (ovc_empty),
        .credit_cnt_all  (credit_cnt_all),
        .credit_err      (credit_err),
        .alloc_err       (alloc_err)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] cnt_of(input int vc);
        return credit_cnt_all[vc*CW +: CW];
    endfunction

    // One clock cycle with the given pulses; outputs are settled 1ns after the edge.
    task automatic cycle(input logic [V-1:0] al, input logic [V-1:0] rl,
                         input logic [V-1:0] fs, input logic [V-1:0] ci);
        ovc_allocated = al;
        ovc_released  = rl;
        flit_sent     = fs;
        credit_in     = ci;
        @(posedge clk);
        #1;
        ovc_allocated = '0;
        ovc_released  = '0;
        flit_sent     = '0;
        credit_in     = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_avail"}, 32'(ovc_avail), 32'hF);
        check_eq({tag, "_empty"}, 32'(ovc_empty), 32'hF);
        check_eq({tag, "_full"}, 32'(ovc_full), 32'h0);
        check_eq({tag, "_nfull"}, 32'(ovc_nearly_full), 32'h0);
        check_eq({tag, "_cnt_all"}, 32'(credit_cnt_all), 32'h924);
        check_eq({tag, "_credit_err"}, 32'(credit_err), 32'h0);
        check_eq({tag, "_alloc_err"}, 32'(alloc_err), 32'h0);
    endtask

    initial begin
        logic [CW-1:0] exp_cnt [4];
        n_checks      = 0;
        n_errors      = 0;
        ovc_allocated = '0;
        ovc_released  = '0;
        flit_sent     = '0;
        credit_in     = '0;
        exp_cnt[0] = 3'd3;
        exp_cnt[1] = 3'd2;
        exp_cnt[2] = 3'd1;
        exp_cnt[3] = 3'd0;

        // Reset then five idle cycles.
        do_reset();
        repeat (5) cycle('0, '0, '0, '0);
        check_reset_state("rst");

        // VC2: allocate, then drain all four credits.
        cycle(4'b0100, '0, '0, '0);
        check_eq("vc2_avail", 32'(ovc_avail), 32'hB);
        check_eq("vc2_empty", 32'(ovc_empty), 32'hB);
        check_eq("vc2_cnt_alloc", 32'(cnt_of(2)), 32'd4);
        for (int k = 0; k < 4; k++) begin
            cycle('0, '0, 4'b0100, '0);
            check_eq($sformatf("vc2_cnt_%0d", k), 32'(cnt_of(2)), 32'(exp_cnt[k]));
            check_eq($sformatf("vc2_nfull_%0d", k), 32'(ovc_nearly_full[2]), (k >= 2) ? 32'd1 : 32'd0);
            check_eq($sformatf("vc2_full_%0d", k), 32'(ovc_full[2]), (k == 3) ? 32'd1 : 32'd0);
        end
        check_eq("vc2_credit_err_pre", 32'(credit_err), 32'd0);
        check_eq("vc2_alloc_err", 32'(alloc_err), 32'd0);
        cycle('0, '0, 4'b0100, '0);
        check_eq("vc2_underflow_err", 32'(credit_err), 32'd1);
        check_eq("vc2_underflow_cnt", 32'(cnt_of(2)), 32'd0);
        cycle('0, '0, '0, '0);
        check_eq("vc2_err_sticky", 32'(credit_err), 32'd1);

        // VC1: back-to-back packets with release+alloc in one cycle.
        do_reset();
        cycle(4'b0010, '0, '0, '0);
        check_eq("vc1_busy", 32'(ovc_avail), 32'hD);
        cycle(4'b0010, 4'b0010, '0, '0);
        check_eq("vc1_b2b_avail", 32'(ovc_avail), 32'hD);
        check_eq("vc1_b2b_alloc_err", 32'(alloc_err), 32'd0);
        cycle('0, 4'b0010, '0, '0);
        check_eq("vc1_release_avail", 32'(ovc_avail), 32'hF);
        check_eq("vc1_release_alloc_err", 32'(alloc_err), 32'd0);

        // VC0: single-flit packet, then its credit comes back.
        do_reset();
        cycle(4'b0001, 4'b0001, 4'b0001, '0);
        check_eq("vc0_sf_avail", 32'(ovc_avail), 32'hF);
        check_eq("vc0_sf_cnt", 32'(cnt_of(0)), 32'd3);
        check_eq("vc0_sf_empty", 32'(ovc_empty), 32'hE);
        check_eq("vc0_sf_alloc_err", 32'(alloc_err), 32'd0);
        cycle('0, '0, '0, 4'b0001);
        check_eq("vc0_cred_cnt", 32'(cnt_of(0)), 32'd4);
        check_eq("vc0_cred_empty", 32'(ovc_empty), 32'hF);
        check_eq("vc0_cred_err", 32'(credit_err), 32'd0);

        // VC3: simultaneous send+credit at zero, then overflow at B.
        do_reset();
        cycle(4'b1000, '0, 4'b1000, '0);
        repeat (3) cycle('0, '0, 4'b1000, '0);
        check_eq("vc3_cnt_zero", 32'(cnt_of(3)), 32'd0);
        cycle('0, '0, 4'b1000, 4'b1000);
        check_eq("vc3_both_cnt", 32'(cnt_of(3)), 32'd0);
        check_eq("vc3_both_err", 32'(credit_err), 32'd0);
        repeat (4) cycle('0, '0, '0, 4'b1000);
        check_eq("vc3_refill_cnt", 32'(cnt_of(3)), 32'd4);
        check_eq("vc3_refill_err", 32'(credit_err), 32'd0);
        cycle('0, '0, '0, 4'b1000);
        check_eq("vc3_overflow_err", 32'(credit_err), 32'd1);
        check_eq("vc3_overflow_cnt", 32'(cnt_of(3)), 32'd4);
        check_eq("vc3_alloc_err", 32'(alloc_err), 32'd0);

        // Ownership-protocol violations.
        do_reset();
        cycle('0, 4'b0100, '0, '0);
        check_eq("rel_idle_err", 32'(alloc_err), 32'd1);
        check_eq("rel_idle_avail", 32'(ovc_avail), 32'hF);
        cycle('0, '0, '0, '0);
        check_eq("alloc_err_sticky", 32'(alloc_err), 32'd1);

        do_reset();
        cycle(4'b0011, '0, '0, '0);
        check_eq("multi_alloc_err", 32'(alloc_err), 32'd1);
        check_eq("multi_alloc_avail", 32'(ovc_avail), 32'hC);

        do_reset();
        cycle('0, 4'b1000, 4'b1000, '0);
        cycle(4'b1000, '0, '0, '0);
        check_eq("multi_rel_pre_err", 32'(alloc_err), 32'd1);

        do_reset();
        cycle('0, '0, 4'b0001, '0);
        check_eq("send_idle_err", 32'(alloc_err), 32'd1);
        check_eq("send_idle_cnt", 32'(cnt_of(0)), 32'd3);

        do_reset();
        cycle(4'b0001, '0, '0, '0);
        check_eq("double_alloc_pre", 32'(alloc_err), 32'd0);
        cycle(4'b0001, '0, '0, '0);
        check_eq("double_alloc_err", 32'(alloc_err), 32'd1);
        check_eq("double_alloc_avail", 32'(ovc_avail), 32'hE);

        do_reset();
        cycle(4'b1000, '0, '0, '0);
        cycle('0, 4'b1100, '0, '0);
        check_eq("multi_release_err", 32'(alloc_err), 32'd1);

        // Asynchronous reset mid-cycle with VC2 busy at count 1 and flags set.
        do_reset();
        cycle('0, '0, 4'b0010, '0);
        cycle(4'b0100, '0, 4'b0100, '0);
        cycle('0, '0, 4'b0100, '0);
        cycle('0, '0, 4'b0100, '0);
        cycle('0, '0, '0, 4'b0001);
        check_eq("pre_arst_cnt2", 32'(cnt_of(2)), 32'd1);
        check_eq("pre_arst_avail", 32'(ovc_avail), 32'hB);
        check_eq("pre_arst_alloc_err", 32'(alloc_err), 32'd1);
        check_eq("pre_arst_credit_err", 32'(credit_err), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("arst");
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_state("post_arst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
